// File: rtl/idc_ctrl.sv
// idc_ctrl: 8x8 image controller. Loads the image from a 2-cycle-latency
// ROM into an internal buffer, applies window move/max/min/average commands
// around the operation point (X,Y), and writes the buffer out to a RAM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | issue ROM addresses 0..63 and capture pixels two cycles later
// ST_IDLE  | accept one command per cycle, BUSY low
// ST_WRITE | stream buffer[0..63] to the RAM, one write per cycle
// ST_DONE  | one-cycle DONE pulse, then back to ST_IDLE
module idc_ctrl (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [3:0] cmd_i,
    input  logic       cmd_valid_i,
    output logic       busy_o,
    output logic [5:0] irom_a_o,
    output logic       irom_cen_o,
    input  logic [7:0] irom_q_i,
    output logic [5:0] iram_a_o,
    output logic [7:0] iram_d_o,
    output logic       iram_we_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e     state_q;
    logic       busy_q;
    logic [5:0] rom_a_q;
    logic       rom_cen_q;
    logic [6:0] iss_q;
    logic       cap_vld_q;
    logic [5:0] cap_idx_q;
    logic [5:0] ram_a_q;
    logic [7:0] ram_d_q;
    logic       ram_we_q;
    logic       done_q;
    logic [5:0] wr_cnt_q;
    logic [2:0] x_q;
    logic [2:0] y_q;
    logic [7:0] buf_q [64];

    // Window geometry: address is {row, col}, so index = row*8 + col.
    logic [2:0] xm1, ym1;
    logic [5:0] idx_tl, idx_tr, idx_bl, idx_br;
    logic [7:0] p_tl, p_tr, p_bl, p_br;
    logic [7:0] max_top, max_bot, min_top, min_bot;
    logic [7:0] win_max, win_min, win_avg;
    logic [9:0] win_sum;
    logic [7:0] win_val_d;
    logic       win_we_d;

    assign xm1    = x_q - 3'd1;
    assign ym1    = y_q - 3'd1;
    assign idx_tl = {ym1, xm1};
    assign idx_tr = {ym1, x_q};
    assign idx_bl = {y_q, xm1};
    assign idx_br = {y_q, x_q};
    assign p_tl   = buf_q[idx_tl];
    assign p_tr   = buf_q[idx_tr];
    assign p_bl   = buf_q[idx_bl];
    assign p_br   = buf_q[idx_br];

    // Reduce the 2x2 window to its max, min and floored average.
    always_comb begin
        max_top   = (p_tl > p_tr) ? p_tl : p_tr;
        max_bot   = (p_bl > p_br) ? p_bl : p_br;
        min_top   = (p_tl < p_tr) ? p_tl : p_tr;
        min_bot   = (p_bl < p_br) ? p_bl : p_br;
        win_max   = (max_top > max_bot) ? max_top : max_bot;
        win_min   = (min_top < min_bot) ? min_top : min_bot;
        win_sum   = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
        win_avg   = win_sum[9:2];
        win_val_d = win_avg;
        win_we_d  = 1'b0;
        if (state_q == ST_IDLE && cmd_valid_i) begin
            case (cmd_i)
                4'd5: begin win_val_d = win_max; win_we_d = 1'b1; end
                4'd6: begin win_val_d = win_min; win_we_d = 1'b1; end
                4'd7: begin win_val_d = win_avg; win_we_d = 1'b1; end
                default: ;
            endcase
        end
    end

    // Image buffer: filled from the load pipeline, rewritten by window ops.
    // Not reset; a reload always follows reset.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_LOAD && cap_vld_q) begin
            buf_q[cap_idx_q] <= irom_q_i;
        end else if (win_we_d) begin
            buf_q[idx_tl] <= win_val_d;
            buf_q[idx_tr] <= win_val_d;
            buf_q[idx_bl] <= win_val_d;
            buf_q[idx_br] <= win_val_d;
        end
    end

    // Main controller FSM with registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_LOAD;
            busy_q    <= 1'b1;
            rom_a_q   <= 6'd0;
            rom_cen_q <= 1'b1;
            iss_q     <= 7'd0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= 6'd0;
            ram_a_q   <= 6'd0;
            ram_d_q   <= 8'd0;
            ram_we_q  <= 1'b0;
            done_q    <= 1'b0;
            wr_cnt_q  <= 6'd0;
            x_q       <= 3'd4;
            y_q       <= 3'd4;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    // Address issued last cycle becomes a capture slot next cycle.
                    cap_vld_q <= ~rom_cen_q;
                    cap_idx_q <= rom_a_q;
                    if (iss_q != 7'd64) begin
                        rom_a_q   <= iss_q[5:0];
                        rom_cen_q <= 1'b0;
                        iss_q     <= iss_q + 7'd1;
                    end else begin
                        rom_cen_q <= 1'b1;
                    end
                    if (cap_vld_q && cap_idx_q == 6'd63) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        case (cmd_i)
                            4'd0: begin
                                state_q  <= ST_WRITE;
                                busy_q   <= 1'b1;
                                wr_cnt_q <= 6'd0;
                            end
                            4'd1: if (y_q > 3'd1) y_q <= y_q - 3'd1;
                            4'd2: if (y_q < 3'd7) y_q <= y_q + 3'd1;
                            4'd3: if (x_q > 3'd1) x_q <= x_q - 3'd1;
                            4'd4: if (x_q < 3'd7) x_q <= x_q + 3'd1;
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (ram_we_q && ram_a_q == 6'd63) begin
                        ram_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        ram_we_q <= 1'b1;
                        ram_a_q  <= wr_cnt_q;
                        ram_d_q  <= buf_q[wr_cnt_q];
                        wr_cnt_q <= wr_cnt_q + 6'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign irom_a_o   = rom_a_q;
    assign irom_cen_o = rom_cen_q;
    assign iram_a_o   = ram_a_q;
    assign iram_d_o   = ram_d_q;
    assign iram_we_o  = ram_we_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_idc_ctrl.sv
// Bench for idc_ctrl: ROM model, reference image model, and a write-out
// scoreboard checked by an independent monitor.
module tb_idc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       busy_o;
    logic [5:0] irom_a_o;
    logic       irom_cen_o;
    logic [7:0] irom_q = 8'd0;
    logic [5:0] iram_a_o;
    logic [7:0] iram_d_o;
    logic       iram_we_o;
    logic       done_o;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;

    logic [7:0]  rom  [64];
    logic [7:0]  mbuf [64];
    int          mx, my;
    logic [13:0] exp_q [$];

    idc_ctrl dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .cmd_i      (cmd),
        .cmd_valid_i(cmd_valid),
        .busy_o     (busy_o),
        .irom_a_o   (irom_a_o),
        .irom_cen_o (irom_cen_o),
        .irom_q_i   (irom_q),
        .iram_a_o   (iram_a_o),
        .iram_d_o   (iram_d_o),
        .iram_we_o  (iram_we_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    // ROM: address seen at edge t+1 is valid on Q before edge t+2.
    always @(posedge clk) begin
        if (!irom_cen_o) irom_q <= rom[irom_a_o];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops expected writes and checks the DONE pulse.
    always @(negedge clk) begin
        logic [13:0] e;
        if (rst_n && iram_we_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got write addr %0d, expected none", iram_a_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {26'd0, iram_a_o}, {26'd0, e[13:8]});
                check("wr_data", {24'd0, iram_d_o}, {24'd0, e[7:0]});
            end
            wr_cnt++;
        end
        if (rst_n && done_o) begin
            check("done_wr_count", wr_cnt, 64);
            check("done_queue_empty", exp_q.size(), 0);
            wr_cnt = 0;
        end
    end

    function automatic void model_cmd(input int c);
        int i0, i1, i2, i3, s;
        logic [7:0] v, a, b, d, f;
        case (c)
            1: if (my > 1) my--;
            2: if (my < 7) my++;
            3: if (mx > 1) mx--;
            4: if (mx < 7) mx++;
            5, 6, 7: begin
                i0 = (my - 1) * 8 + mx - 1;
                i1 = (my - 1) * 8 + mx;
                i2 = my * 8 + mx - 1;
                i3 = my * 8 + mx;
                a = mbuf[i0]; b = mbuf[i1]; d = mbuf[i2]; f = mbuf[i3];
                if (c == 5) begin
                    v = a;
                    if (b > v) v = b;
                    if (d > v) v = d;
                    if (f > v) v = f;
                end else if (c == 6) begin
                    v = a;
                    if (b < v) v = b;
                    if (d < v) v = d;
                    if (f < v) v = f;
                end else begin
                    s = int'(a) + int'(b) + int'(d) + int'(f);
                    v = 8'(s / 4);
                end
                mbuf[i0] = v; mbuf[i1] = v; mbuf[i2] = v; mbuf[i3] = v;
            end
            default: ;
        endcase
    endfunction

    task automatic assert_reset_now();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy_o}, 1);
        check("rst_cen", {31'd0, irom_cen_o}, 1);
        check("rst_rom_a", {26'd0, irom_a_o}, 0);
        check("rst_we", {31'd0, iram_we_o}, 0);
        check("rst_ram_a", {26'd0, iram_a_o}, 0);
        check("rst_ram_d", {24'd0, iram_d_o}, 0);
        check("rst_done", {31'd0, done_o}, 0);
        exp_q.delete();
        wr_cnt = 0;
        for (int i = 0; i < 64; i++) mbuf[i] = rom[i];
        mx = 4;
        my = 4;
    endtask

    task automatic release_load();
        int cyc, cen_lo, dn;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; cen_lo = 0; dn = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!irom_cen_o) cen_lo++;
            if (done_o) dn++;
            if (!busy_o) break;
        end
        check("load_cycles", cyc, 66);
        check("load_cen_low", cen_lo, 64);
        check("load_no_done", dn, 0);
    endtask

    task automatic reset_and_load();
        @(negedge clk);
        assert_reset_now();
        release_load();
    endtask

    task automatic do_cmd(input int c);
        @(negedge clk);
        check("cmd_idle_busy", {31'd0, busy_o}, 0);
        cmd = 4'(c);
        cmd_valid = 1'b1;
        model_cmd(c);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_busy_after", {31'd0, busy_o}, 0);
    endtask

    task automatic start_writeout();
        @(negedge clk);
        check("wo_idle_busy", {31'd0, busy_o}, 0);
        for (int i = 0; i < 64; i++) exp_q.push_back({i[5:0], mbuf[i]});
        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wo_busy_rise", {31'd0, busy_o}, 1);
    endtask

    task automatic writeout(input bit hold2);
        bit found;
        start_writeout();
        if (hold2) begin
            cmd = 4'd2;
            cmd_valid = 1'b1;
        end
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (done_o) found = 1'b1;
        end
        check("wo_done_seen", {31'd0, found}, 1);
        check("wo_done_busy", {31'd0, busy_o}, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wo_done_single", {31'd0, done_o}, 0);
        check("wo_busy_fall", {31'd0, busy_o}, 0);
    endtask

    task automatic abort_writeout(input int at);
        bit found;
        start_writeout();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (iram_we_o && iram_a_o == 6'(at)) found = 1'b1;
        end
        check("abort_reached", {31'd0, found}, 1);
        assert_reset_now();
        release_load();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
        // Identity image load and write-out.
        reset_and_load();
        writeout(1'b0);
        // Move to (1,1) with saturation, then average.
        for (int i = 0; i < 5; i++) do_cmd(1);
        for (int i = 0; i < 5; i++) do_cmd(3);
        do_cmd(7);
        writeout(1'b0);
        // Commands during write-out are dropped; illegal codes ignored.
        writeout(1'b1);
        do_cmd(15);
        do_cmd(4);
        do_cmd(5);
        writeout(1'b0);
        // Reset in the middle of a write-out.
        abort_writeout(20);
        do_cmd(5);
        writeout(1'b0);
        // Right-edge saturation from (4,4).
        reset_and_load();
        for (int i = 0; i < 4; i++) do_cmd(4);
        do_cmd(4);
        do_cmd(6);
        writeout(1'b0);
        // Saturating-range window values.
        rom[27] = 8'd255; rom[28] = 8'd255; rom[35] = 8'd255; rom[36] = 8'd254;
        reset_and_load();
        do_cmd(7);
        writeout(1'b0);
        reset_and_load();
        do_cmd(5);
        writeout(1'b0);
        rom[27] = 8'd10; rom[28] = 8'd3; rom[35] = 8'd7; rom[36] = 8'd200;
        reset_and_load();
        do_cmd(6);
        writeout(1'b0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/idc_ctrl.md
IDC_CTRL -- requirements
Module: idc_ctrl

Interface
REQ-001 The block SHALL have no parameters: image fixed at 8x8 pixels, 8 bits/pixel, addr = row*8 + col.
REQ-002 CLK  input  1  single clock, all state updated on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 CMD  input  4  command code, sampled only when CMD_VALID=1.
REQ-005 CMD_VALID  input  1  command strobe.
REQ-006 BUSY  output  1  high = commands are not accepted.
REQ-007 IROM_A  output  6  source ROM address.
REQ-008 IROM_CEN  output  1  ROM address enable, active-low.
REQ-009 IROM_Q  input  8  ROM read data.
REQ-010 IRAM_A  output  6  result RAM write address.
REQ-011 IRAM_D  output  8  result RAM write data.
REQ-012 IRAM_WE  output  1  result RAM write strobe, active-high.
REQ-013 DONE  output  1  one-cycle pulse at the end of a write-out.

Function
REQ-014 The ROM SHALL be treated as a 2-cycle read: an address driven from a rising edge at cycle t, with IROM_CEN=0, yields valid IROM_Q to be captured at the rising edge of cycle t+2.
REQ-015 The FSM SHALL have states LOAD, IDLE, WRITE, DONE_ST; LOAD is entered on reset release.
REQ-016 LOAD SHALL issue addresses 0..63 on consecutive cycles with IROM_CEN=0, pipeline-capture pixel k into buffer[k] two cycles later, drive IROM_CEN=1 after address 63, and enter IDLE on the cycle after pixel 63 is captured; the total is 66 cycles.
REQ-017 The block SHALL keep an operation point (X,Y), reset to (4,4), with range 1..7 each; it defines the 2x2 window (X-1,Y-1),(X,Y-1),(X-1,Y),(X,Y) in (col,row) order.
REQ-018 In IDLE, BUSY SHALL be 0 and CMD_VALID=1 SHALL accept CMD in that cycle; ops 1-7 SHALL complete by the next rising edge and BUSY SHALL stay 0.
REQ-019 CMD=1 up: Y-=1, saturating at 1; CMD=2 down: Y+=1, saturating at 7; CMD=3 left: X-=1, saturating at 1; CMD=4 right: X+=1, saturating at 7.
REQ-020 CMD=5 max and CMD=6 min SHALL overwrite all four window pixels with the max/min of the four.
REQ-021 CMD=7 average SHALL overwrite all four window pixels with floor(sum/4); the sum SHALL be computed at 10 bits so there is no overflow.
REQ-022 CMD=0 write-out SHALL enter WRITE, set BUSY=1 from the next cycle, and emit 64 consecutive writes with IRAM_WE=1, IRAM_A=0..63, IRAM_D=buffer[IRAM_A].
REQ-023 After the write to address 63, DONE_ST SHALL assert DONE=1 for exactly one cycle, BUSY SHALL remain 1 in that cycle, and the FSM SHALL then return to IDLE; the buffer and (X,Y) are unchanged by write-out.
REQ-024 CMD values 8-15 SHALL be ignored and cause no state change.
REQ-025 CMD_VALID while BUSY=1 SHALL be dropped, not queued.
REQ-026 IRAM_WE SHALL be 0 outside WRITE; IROM_CEN SHALL be 1 outside LOAD address issue.

Reset
REQ-027 RESET_N=0 SHALL immediately force: state=LOAD pending, BUSY=1, IROM_CEN=1, IROM_A=0, IRAM_WE=0, IRAM_A=0, IRAM_D=0, DONE=0, (X,Y)=(4,4), and the load pipeline cleared.
REQ-028 Buffer contents need not reset; a reset asserted mid-LOAD or mid-WRITE SHALL abort it, and after release the full load SHALL restart from address 0.

Verification
REQ-029 ROM holding pixel[k]=k; reset release; CMD=0 -> BUSY low after 66 cycles, 64 writes with IRAM_D=IRAM_A, then a single DONE pulse.
REQ-030 After load, CMD=1 x5 then CMD=3 x5 -> (X,Y)=(1,1); CMD=7 -> pixels 0,1,8,9 = floor(18/4)=4; write-out confirms this and all other pixels are unchanged.
REQ-031 Window pixels 255,255,255,254; CMD=7 -> 254; CMD=5 -> 255; CMD=6 on 10,3,7,200 -> all 3.
REQ-032 CMD_VALID asserted with CMD=2 throughout a write-out -> Y is unchanged afterward; CMD=15 in IDLE -> no change.
REQ-033 RESET_N pulsed low at write address 20 -> IRAM_WE=0 immediately, no DONE, reload of 66 cycles, (X,Y)=(4,4).
REQ-034 CMD=4 x4 from (4,4) -> X=7, and a further CMD=4 leaves X=7.
